bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder.sv | 133 +++++++++++++
 tb/tb_bus_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Word-addressed register responder: an 8-word window with control, scratch,
// free-running counter, error counter and four data words. Every request
// completes one cycle after it is sampled with exactly one of ack/rvalid/err.
module bus_responder #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] CNT_INIT  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        ws,
   input  logic        oe,
   output logic [15:0] rdata,
   output logic        rvalid,
   output logic        ack,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WACK, RDAT, ERR} state_t;

   state_t      state_q, state_d;
   logic [1:0]  fmt_q;
   logic [15:0] scratch_q;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] errcnt_q, errcnt_d;
   logic [15:0] data_q [4];
   logic [15:0] rdata_q;

   logic [15:0] off;
   logic        in_win;
   logic [2:0]  idx;
   logic        do_wr, do_rd, do_err;
   logic [15:0] raw_rd, fmt_rd;

   // Apply the CTRL.FMT read transform.
   function automatic logic [15:0] fmt_apply(input logic [15:0] v, input logic [1:0] f);
      logic [15:0] r;
      r = v;
      case (f)
         2'd1:    for (int i = 0; i < 16; i++) r[i] = v[15-i];
         2'd2:    r = {v[3:0], v[7:4], v[11:8], v[15:12]};
         2'd3:    r = {v[7:0], v[15:8]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Decode the request; only IDLE accepts, and a conflicting or out-of-window strobe is an error.
   always_comb begin
      off    = addr - BASE_ADDR;
      in_win = (off[15:3] == 13'd0);
      idx    = off[2:0];
      do_wr  = (state_q == IDLE) && ws && !oe && in_win;
      do_rd  = (state_q == IDLE) && oe && !ws && in_win;
      do_err = (state_q == IDLE) && (ws || oe) && !(do_wr || do_rd);
   end

   // Read mux, with the format transform applied to the data-like registers only.
   always_comb begin
      raw_rd = 16'h0000;
      case (idx)
         3'd0:    raw_rd = {14'd0, fmt_q};
         3'd1:    raw_rd = scratch_q;
         3'd2:    raw_rd = cnt_q;
         3'd3:    raw_rd = errcnt_q;
         default: raw_rd = data_q[idx[1:0]];
      endcase
      if (idx == 3'd1 || idx[2])
         fmt_rd = fmt_apply(raw_rd, fmt_q);
      else
         fmt_rd = raw_rd;
   end

   // Next state and counter next values.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (do_wr)       state_d = WACK;
            else if (do_rd)  state_d = RDAT;
            else if (do_err) state_d = ERR;
            else             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (do_wr && idx == 3'd2) cnt_d = CNT_INIT;
      else                      cnt_d = cnt_q + 16'd1;

      errcnt_d = errcnt_q;
      if (do_wr && idx == 3'd3)                errcnt_d = 16'h0000;
      else if (do_err && errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
   end

   // State, control, scratch, counters and captured read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         fmt_q     <= 2'd0;
         scratch_q <= 16'h0000;
         cnt_q     <= CNT_INIT;
         errcnt_q  <= 16'h0000;
         rdata_q   <= 16'h0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         errcnt_q <= errcnt_d;
         rdata_q  <= do_rd ? fmt_rd : 16'h0000;
         if (do_wr && idx == 3'd0) fmt_q     <= wdata[1:0];
         if (do_wr && idx == 3'd1) scratch_q <= wdata;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_data
         // DATA word gi, written at window offset 4+gi.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               data_q[gi] <= 16'h0000;
            else if (do_wr && idx == 3'(4 + gi))
               data_q[gi] <= wdata;
         end
      end
   endgenerate

   assign ack    = (state_q == WACK);
   assign rvalid = (state_q == RDAT);
   assign err    = (state_q == ERR);
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: format transforms, error paths, counter
// behaviour, reset abort and error-counter saturation.
module tb_bus_responder;

   localparam logic [15:0] BASE = 16'h0040;
   localparam logic [15:0] CINIT = 16'hFFF0;
   localparam logic [15:0] A_CTRL = BASE + 16'd0;
   localparam logic [15:0] A_SCR  = BASE + 16'd1;
   localparam logic [15:0] A_CNT  = BASE + 16'd2;
   localparam logic [15:0] A_ERRC = BASE + 16'd3;
   localparam logic [15:0] A_DAT0 = BASE + 16'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] wdata = 16'h0000;
   logic        ws = 1'b0;
   logic        oe = 1'b0;
   logic [15:0] rdata;
   logic        rvalid, ack, err;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit quiet = 1'b0;

   bus_responder #(.BASE_ADDR(BASE), .CNT_INIT(CINIT)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .ws(ws), .oe(oe),
      .rdata(rdata), .rvalid(rvalid), .ack(ack), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // One request: drive on a falling edge, observe the completion one falling edge later.
   task automatic bus_op(input logic w, input logic o, input logic [15:0] a, input logic [15:0] d,
                         output logic ack_s, output logic rv_s, output logic err_s,
                         output logic [15:0] rd_s, output int samp);
      @(negedge clk);
      ws = w; oe = o; addr = a; wdata = d;
      samp = cyc + 1;
      @(negedge clk);
      ws = 1'b0; oe = 1'b0;
      ack_s = ack; rv_s = rvalid; err_s = err; rd_s = rdata;
      if (!quiet)
         $display("op ws=%0b oe=%0b addr=%h wdata=%h -> ack=%0b rvalid=%0b err=%0b rdata=%h",
                  w, o, a, d, ack_s, rv_s, err_s, rd_s);
   endtask

   task automatic test_reset();
      logic a, r, e; logic [15:0] rd; int s;
      repeat (2) @(negedge clk);
      vectors++;
      if ({ack, rvalid, err, rdata} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ack=%0b rvalid=%0b err=%0b rdata=%h want all 0", ack, rvalid, err, rdata);
      end
      // Release and request on the very first edge.
      rst_n = 1'b1; ws = 1'b1; addr = A_SCR; wdata = 16'h00AA;
      @(negedge clk);
      ws = 1'b0;
      vectors++;
      if (ack !== 1'b1) begin
         miscompares++; $display("FAIL first_edge_write: ack=%0b want 1", ack);
      end
      $display("op first write after reset -> ack=%0b", ack);
      bus_op(0, 1, A_CTRL, 0, a, r, e, rd, s);
      vectors++;
      if (r !== 1'b1 || rd !== 16'h0000) begin
         miscompares++; $display("FAIL reset_ctrl: rvalid=%0b rdata=%h want 1/0000", r, rd);
      end
      bus_op(0, 1, A_ERRC, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++; $display("FAIL reset_errcnt: rdata=%h want 0000", rd);
      end
      bus_op(0, 1, A_DAT0 + 16'd3, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++; $display("FAIL reset_data3: rdata=%h want 0000", rd);
      end
   endtask

   task automatic test_format();
      logic a, r, e; logic [15:0] rd; int s;
      logic [1:0]  fmts [4]  = '{2'd2, 2'd3, 2'd1, 2'd0};
      logic [15:0] exps [4]  = '{16'h4321, 16'h3412, 16'h2C48, 16'h1234};
      logic [15:0] dvals [4] = '{16'hA1B2, 16'hC3D4, 16'h0F00, 16'h8001};
      logic [15:0] dnib [4]  = '{16'h2B1A, 16'h4D3C, 16'h00F0, 16'h1008};
      bus_op(1, 0, A_SCR, 16'h1234, a, r, e, rd, s);
      vectors++;
      if (a !== 1'b1 || r !== 1'b0 || e !== 1'b0 || rd !== 16'h0000) begin
         miscompares++; $display("FAIL scratch_write: ack=%0b rvalid=%0b err=%0b rdata=%h want 1/0/0/0000", a, r, e, rd);
      end
      for (int i = 0; i < 4; i++) begin
         bus_op(1, 0, A_CTRL, {14'd0, fmts[i]}, a, r, e, rd, s);
         bus_op(0, 1, A_SCR, 0, a, r, e, rd, s);
         vectors++;
         if (r !== 1'b1 || a !== 1'b0 || e !== 1'b0 || rd !== exps[i]) begin
            miscompares++;
            $display("FAIL fmt%0d_scratch: rvalid=%0b rdata=%h want 1/%h", fmts[i], r, rd, exps[i]);
         end
      end
      for (int i = 0; i < 4; i++) bus_op(1, 0, A_DAT0 + 16'(i), dvals[i], a, r, e, rd, s);
      bus_op(1, 0, A_CTRL, 16'hFFFE, a, r, e, rd, s);
      bus_op(0, 1, A_CTRL, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0002) begin
         miscompares++; $display("FAIL ctrl_upper_bits: rdata=%h want 0002", rd);
      end
      for (int i = 0; i < 4; i++) begin
         bus_op(0, 1, A_DAT0 + 16'(i), 0, a, r, e, rd, s);
         vectors++;
         if (rd !== dnib[i]) begin
            miscompares++; $display("FAIL fmt2_data%0d: rdata=%h want %h", i, rd, dnib[i]);
         end
      end
      bus_op(1, 0, A_CTRL, 16'h0000, a, r, e, rd, s);
   endtask

   task automatic test_errors();
      logic a, r, e; logic [15:0] rd; int s;
      bus_op(1, 0, A_ERRC, 16'h5A5A, a, r, e, rd, s);
      bus_op(1, 1, A_SCR, 16'hDEAD, a, r, e, rd, s);
      vectors++;
      if (e !== 1'b1 || a !== 1'b0 || r !== 1'b0) begin
         miscompares++; $display("FAIL both_strobes: err=%0b ack=%0b rvalid=%0b want 1/0/0", e, a, r);
      end
      bus_op(0, 1, A_SCR, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h1234) begin
         miscompares++; $display("FAIL scratch_kept: rdata=%h want 1234", rd);
      end
      // Byte swap active: ERRCNT must still read unswapped.
      bus_op(1, 0, A_CTRL, 16'h0003, a, r, e, rd, s);
      bus_op(0, 1, A_ERRC, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0001) begin
         miscompares++; $display("FAIL errcnt_one: rdata=%h want 0001", rd);
      end
      bus_op(1, 0, A_ERRC, 16'hFFFF, a, r, e, rd, s);
      bus_op(0, 1, A_ERRC, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++; $display("FAIL errcnt_clear: rdata=%h want 0000", rd);
      end
      bus_op(1, 0, A_CTRL, 16'h0000, a, r, e, rd, s);
   endtask

   task automatic test_window();
      logic a, r, e; logic [15:0] rd; int s;
      bus_op(0, 1, BASE + 16'd8, 0, a, r, e, rd, s);
      vectors++;
      if (e !== 1'b1 || r !== 1'b0 || rd !== 16'h0000) begin
         miscompares++; $display("FAIL read_above: err=%0b rvalid=%0b rdata=%h want 1/0/0000", e, r, rd);
      end
      bus_op(1, 0, BASE - 16'd1, 16'h7777, a, r, e, rd, s);
      vectors++;
      if (e !== 1'b1 || a !== 1'b0) begin
         miscompares++; $display("FAIL write_below: err=%0b ack=%0b want 1/0", e, a);
      end
      bus_op(0, 1, A_ERRC, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0002) begin
         miscompares++; $display("FAIL errcnt_two: rdata=%h want 0002", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic a, r, e; logic [15:0] rd; int s;
      @(negedge clk);
      ws = 1'b1; addr = A_SCR; wdata = 16'hBEEF;
      @(negedge clk);
      wdata = 16'hCAFE;
      vectors++;
      if (ack !== 1'b1) begin
         miscompares++; $display("FAIL b2b_first_ack: ack=%0b want 1", ack);
      end
      @(negedge clk);
      ws = 1'b0;
      vectors++;
      if ({ack, rvalid, err} !== 3'b000) begin
         miscompares++; $display("FAIL b2b_ignored: ack=%0b rvalid=%0b err=%0b want 0/0/0", ack, rvalid, err);
      end
      $display("op held write strobe -> second cycle ack=%0b err=%0b", ack, err);
      bus_op(0, 1, A_SCR, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'hBEEF) begin
         miscompares++; $display("FAIL b2b_data: rdata=%h want beef", rd);
      end
   endtask

   task automatic test_count();
      logic a, r, e; logic [15:0] rd, expv; int s, w;
      bus_op(1, 0, A_CNT, 16'h1111, a, r, e, rd, w);
      vectors++;
      if (a !== 1'b1) begin
         miscompares++; $display("FAIL count_write_ack: ack=%0b want 1", a);
      end
      bus_op(0, 1, A_CNT, 0, a, r, e, rd, s);
      expv = CINIT + 16'(s - w - 1);
      vectors++;
      if (rd !== expv || expv !== 16'hFFF1) begin
         miscompares++; $display("FAIL count_near: rdata=%h want %h", rd, expv);
      end
      repeat (20) @(negedge clk);
      bus_op(0, 1, A_CNT, 0, a, r, e, rd, s);
      expv = CINIT + 16'(s - w - 1);
      vectors++;
      if (rd !== expv) begin
         miscompares++; $display("FAIL count_wrapped: rdata=%h want %h", rd, expv);
      end
   endtask

   task automatic test_reset_abort();
      logic a, r, e; logic [15:0] rd, expv; int s, rel, pulses;
      bus_op(1, 0, A_SCR, 16'h5555, a, r, e, rd, s);
      bus_op(1, 0, A_DAT0 + 16'd2, 16'h7777, a, r, e, rd, s);
      bus_op(1, 0, A_CTRL, 16'h0002, a, r, e, rd, s);
      bus_op(1, 1, A_SCR, 0, a, r, e, rd, s);
      @(negedge clk);
      oe = 1'b1; addr = A_SCR;
      @(posedge clk);
      #1 rst_n = 1'b0; oe = 1'b0;
      pulses = 0;
      repeat (2) begin
         @(negedge clk);
         if (rvalid !== 1'b0 || rdata !== 16'h0000) pulses++;
      end
      rst_n = 1'b1;
      rel = cyc;
      repeat (3) begin
         @(negedge clk);
         if (rvalid !== 1'b0 || ack !== 1'b0 || err !== 1'b0) pulses++;
      end
      $display("op reset during read -> late pulses=%0d", pulses);
      vectors++;
      if (pulses !== 0) begin
         miscompares++; $display("FAIL abort_no_rvalid: pulses=%0d want 0", pulses);
      end
      bus_op(0, 1, A_SCR, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++; $display("FAIL abort_scratch: rdata=%h want 0000", rd);
      end
      bus_op(0, 1, A_DAT0 + 16'd2, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++; $display("FAIL abort_data2: rdata=%h want 0000", rd);
      end
      bus_op(0, 1, A_ERRC, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++; $display("FAIL abort_errcnt: rdata=%h want 0000", rd);
      end
      bus_op(0, 1, A_CNT, 0, a, r, e, rd, s);
      expv = CINIT + 16'(s - rel - 1);
      vectors++;
      if (rd !== expv) begin
         miscompares++; $display("FAIL abort_count: rdata=%h want %h", rd, expv);
      end
   endtask

   task automatic test_saturate();
      logic a, r, e; logic [15:0] rd, expv; int s, w, nerr;
      bus_op(1, 0, A_ERRC, 0, a, r, e, rd, s);
      bus_op(1, 0, A_CNT, 0, a, r, e, rd, w);
      quiet = 1'b1;
      nerr = 0;
      for (int i = 0; i < 65537; i++) begin
         bus_op(1, 1, A_CTRL, 16'h0001, a, r, e, rd, s);
         if (e === 1'b1 && a === 1'b0 && r === 1'b0) nerr++;
      end
      quiet = 1'b0;
      $display("op 65537 conflicting requests -> err pulses=%0d", nerr);
      vectors++;
      if (nerr !== 65537) begin
         miscompares++; $display("FAIL sat_err_pulses: got %0d want 65537", nerr);
      end
      bus_op(0, 1, A_ERRC, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'hFFFF) begin
         miscompares++; $display("FAIL sat_errcnt: rdata=%h want ffff", rd);
      end
      repeat (3) bus_op(0, 1, BASE + 16'd100, 0, a, r, e, rd, s);
      bus_op(0, 1, A_ERRC, 0, a, r, e, rd, s);
      vectors++;
      if (rd !== 16'hFFFF) begin
         miscompares++; $display("FAIL sat_errcnt_hold: rdata=%h want ffff", rd);
      end
      bus_op(0, 1, A_CNT, 0, a, r, e, rd, s);
      expv = CINIT + 16'(s - w - 1);
      vectors++;
      if (rd !== expv) begin
         miscompares++; $display("FAIL long_count: rdata=%h want %h after %0d cycles", rd, expv, s - w);
      end
   endtask

   initial begin
      test_reset();
      test_format();
      test_errors();
      test_window();
      test_back_to_back();
      test_count();
      test_reset_abort();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
